mem_copy_initiator: RTL and testbench
=====================================

Name: mem_copy_initiator

Overview:
- Command-side initiator for the single-byte cmd/rsp memory protocol: cmd_valid/cmd_ready with a 2-bit type (0 NOP, 1 READ, 2 WRITE), and rsp_valid/rsp_ready.
- Copies a block of len bytes from src_addr to dst_addr as one READ followed by one WRITE per byte.
- Keeps at most one command outstanding at any time.
- Sits between the systolic-array tile sequencer and the memory controller; used to stage operand tiles.

Parameters:
- DATA_WIDTH, 8, width of cmd_data and rsp_data.
- ADDR_WIDTH, 16, width of all byte addresses.
- LEN_WIDTH, 17, width of len and bytes_done; covers 0..2^ADDR_WIDTH bytes.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- src_addr  in  ADDR_WIDTH  first source byte address; captured on accepted start.
- dst_addr  in  ADDR_WIDTH  first destination byte address; captured on accepted start.
- len  in  LEN_WIDTH  byte count; captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- bytes_done  out  LEN_WIDTH  count of bytes whose WRITE has been accepted.
- cmd_valid  out  1  command request.
- cmd_type  out  2  1 = READ, 2 = WRITE; 0 whenever cmd_valid is low.
- cmd_addr  out  ADDR_WIDTH  command address.
- cmd_data  out  DATA_WIDTH  write data; 0 for READ.
- cmd_ready  in  1  responder accepts the command when cmd_valid && cmd_ready.
- rsp_valid  in  1  read response valid.
- rsp_data  in  DATA_WIDTH  read response data.
- rsp_ready  out  1  initiator ready for a response.

Behaviour:
- Reset: all outputs 0 (busy, done, bytes_done, cmd_valid, cmd_type, cmd_addr, cmd_data, rsp_ready); state = IDLE; internal byte register 0.
- Reset applies immediately and asynchronously, including mid-transfer. The in-flight command is dropped; no recovery or replay.
- All outputs are registered.
- FSM states: IDLE, RD_CMD, RD_WAIT, WR_CMD, NEXT, FIN.
- IDLE:
  - On start: capture src/dst/len, clear bytes_done and the index i.
  - If len == 0, go to FIN; otherwise go to RD_CMD and set busy = 1.
  - start is ignored in every state other than IDLE.
- RD_CMD: cmd_valid = 1, cmd_type = 1, cmd_addr = src + i (mod 2^ADDR_WIDTH), cmd_data = 0.
  - All cmd fields stay stable until cmd_valid && cmd_ready.
  - On that handshake: cmd_valid drops next cycle, rsp_ready rises next cycle, go to RD_WAIT.
- RD_WAIT: rsp_ready = 1.
  - On rsp_valid && rsp_ready: latch rsp_data, drop rsp_ready, go to WR_CMD.
  - Wait indefinitely; there is no timeout.
- WR_CMD: cmd_valid = 1, cmd_type = 2, cmd_addr = dst + i (mod 2^ADDR_WIDTH), cmd_data = latched byte.
  - Fields stay stable until accepted.
  - On acceptance: bytes_done += 1, go to NEXT.
- NEXT: i += 1.
  - If i == len, go to FIN; otherwise go to RD_CMD.
  - This gives one idle cycle between WRITE acceptance and the next READ; the responder needs it to return to its idle state.
- FIN: done = 1 for exactly one cycle, busy = 0, go to IDLE.
- rsp_valid outside RD_WAIT is ignored; rsp_ready stays 0 there.
- cmd_valid and rsp_ready are never high together.
- Never issue NOP.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; e.g. src = 0xFFFF, len = 2 reads 0xFFFF then 0x0000.
- Overlapping regions: the copy is strictly ascending, one byte at a time. The result equals a sequential forward byte copy, including the smear when dst > src.
- Minimum per-byte time with a zero-wait responder: 1 cycle RD_CMD + ≥1 cycle RD_WAIT + 1 cycle WR_CMD + 1 cycle NEXT.

Optional Feature:
- Macro MEM_COPY_CHECKSUM_EN.
- Defined:
  - Extra output port checksum, 16 bits.
  - Reset value 0; cleared on accepted start.
  - Adds zero-extended rsp_data, modulo 2^16, on each accepted response.
  - Stable from FIN until the next start.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic copy: preload mem[0x0100..0x0103] = 11,22,33,44; start src = 0x0100, dst = 0x0200, len = 4.
  - mem[0x0200..0x0203] = 11,22,33,44.
  - Command order is R,W,R,W,R,W,R,W.
  - bytes_done = 4; done pulses once; busy falls with done.
- Zero length: start with len = 0.
  - No cmd_valid ever asserted.
  - done pulses 2 cycles after start; bytes_done = 0.
- Backpressure: hold cmd_ready low 5 cycles on each command and delay rsp_valid 3 cycles.
  - cmd_addr/cmd_type/cmd_data stay stable while stalled.
  - Data copies correctly.
- Wrap: src = 0xFFFE, dst = 0x0010, len = 4.
  - Reads hit 0xFFFE, 0xFFFF, 0x0000, 0x0001.
  - Writes hit 0x0010..0x0013.
- Reset mid-transfer: assert rst during RD_WAIT of byte 2 of an 8-byte copy.
  - cmd_valid, rsp_ready, and busy go to 0 without waiting for a clock edge.
  - bytes_done = 0; a new start then completes normally.
- MEM_COPY_CHECKSUM_EN: copy bytes 0xFF ×3 plus 0x05.
  - checksum = 0x0302; a second start clears it first.

Source files
------------

// File: rtl/mem_copy_initiator.sv
// Block-copy initiator for the single-byte cmd/rsp memory protocol: one READ then one WRITE per byte,
// one command outstanding at a time. Define MEM_COPY_CHECKSUM_EN to add a 16-bit sum of bytes read.
module mem_copy_initiator #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  bytes_done,
  output logic                  cmd_valid,
  output logic [1:0]            cmd_type,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [DATA_WIDTH-1:0] cmd_data,
  input  logic                  cmd_ready,
  input  logic                  rsp_valid,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_ready
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [15:0]           checksum
`endif
);

  localparam logic [1:0] CMD_READ  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_WAIT, WR_CMD, NEXT, FIN} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] src_reg, src_next;
  logic [ADDR_WIDTH-1:0] dst_reg, dst_next;
  logic [LEN_WIDTH-1:0]  len_reg, len_next;
  logic [LEN_WIDTH-1:0]  idx_reg, idx_next;
  logic [LEN_WIDTH-1:0]  idx_inc;

  logic                  busy_next, done_next, cmd_valid_next, rsp_ready_next;
  logic [LEN_WIDTH-1:0]  bytes_done_next;
  logic [1:0]            cmd_type_next;
  logic [ADDR_WIDTH-1:0] cmd_addr_next;
  logic [DATA_WIDTH-1:0] cmd_data_next;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [15:0]           checksum_next;
`endif

  assign idx_inc = idx_reg + LEN_WIDTH'(1);

  // Output registers are loaded with the values for the state being entered, so every
  // output is a flop and the command fields hold still while a command is stalled.
  always_comb begin
    state_next      = state_reg;
    src_next        = src_reg;
    dst_next        = dst_reg;
    len_next        = len_reg;
    idx_next        = idx_reg;
    busy_next       = busy;
    done_next       = 1'b0;
    bytes_done_next = bytes_done;
    cmd_valid_next  = cmd_valid;
    cmd_type_next   = cmd_type;
    cmd_addr_next   = cmd_addr;
    cmd_data_next   = cmd_data;
    rsp_ready_next  = rsp_ready;
`ifdef MEM_COPY_CHECKSUM_EN
    checksum_next   = checksum;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          src_next        = src_addr;
          dst_next        = dst_addr;
          len_next        = len;
          idx_next        = '0;
          bytes_done_next = '0;
`ifdef MEM_COPY_CHECKSUM_EN
          checksum_next   = '0;
`endif
          if (len == '0) begin
            state_next = FIN;
          end else begin
            state_next     = RD_CMD;
            busy_next      = 1'b1;
            cmd_valid_next = 1'b1;
            cmd_type_next  = CMD_READ;
            cmd_addr_next  = src_addr;
            cmd_data_next  = '0;
          end
        end
      end
      RD_CMD: begin
        if (cmd_valid && cmd_ready) begin
          state_next     = RD_WAIT;
          cmd_valid_next = 1'b0;
          cmd_type_next  = 2'd0;
          cmd_addr_next  = '0;
          rsp_ready_next = 1'b1;
        end
      end
      RD_WAIT: begin
        // cmd_data doubles as the latched byte until its WRITE is accepted.
        if (rsp_valid && rsp_ready) begin
          state_next     = WR_CMD;
          rsp_ready_next = 1'b0;
          cmd_valid_next = 1'b1;
          cmd_type_next  = CMD_WRITE;
          cmd_addr_next  = dst_reg + idx_reg[ADDR_WIDTH-1:0];
          cmd_data_next  = rsp_data;
`ifdef MEM_COPY_CHECKSUM_EN
          checksum_next  = checksum + 16'(rsp_data);
`endif
        end
      end
      WR_CMD: begin
        if (cmd_valid && cmd_ready) begin
          state_next      = NEXT;
          bytes_done_next = bytes_done + LEN_WIDTH'(1);
          cmd_valid_next  = 1'b0;
          cmd_type_next   = 2'd0;
          cmd_addr_next   = '0;
          cmd_data_next   = '0;
        end
      end
      NEXT: begin
        // Single idle cycle between a WRITE and the next READ lets the responder settle.
        idx_next = idx_inc;
        if (idx_inc == len_reg) begin
          state_next = FIN;
        end else begin
          state_next     = RD_CMD;
          cmd_valid_next = 1'b1;
          cmd_type_next  = CMD_READ;
          cmd_addr_next  = src_reg + idx_inc[ADDR_WIDTH-1:0];
          cmd_data_next  = '0;
        end
      end
      FIN: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      src_reg    <= '0;
      dst_reg    <= '0;
      len_reg    <= '0;
      idx_reg    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bytes_done <= '0;
      cmd_valid  <= 1'b0;
      cmd_type   <= 2'd0;
      cmd_addr   <= '0;
      cmd_data   <= '0;
      rsp_ready  <= 1'b0;
`ifdef MEM_COPY_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      src_reg    <= src_next;
      dst_reg    <= dst_next;
      len_reg    <= len_next;
      idx_reg    <= idx_next;
      busy       <= busy_next;
      done       <= done_next;
      bytes_done <= bytes_done_next;
      cmd_valid  <= cmd_valid_next;
      cmd_type   <= cmd_type_next;
      cmd_addr   <= cmd_addr_next;
      cmd_data   <= cmd_data_next;
      rsp_ready  <= rsp_ready_next;
`ifdef MEM_COPY_CHECKSUM_EN
      checksum   <= checksum_next;
`endif
    end
  end

endmodule

// File: tb/tb_mem_copy_initiator.sv
// Self-checking bench for mem_copy_initiator: a randomized memory responder plus a forward-copy reference model.
// Honours MEM_COPY_CHECKSUM_EN when defined.
module tb_mem_copy_initiator;
  logic        clk, rst, start;
  logic [15:0] src_addr, dst_addr;
  logic [16:0] len;
  logic        busy, done;
  logic [16:0] bytes_done;
  logic        cmd_valid;
  logic [1:0]  cmd_type;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        cmd_ready, rsp_valid, rsp_ready;
  logic [7:0]  rsp_data;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  mem_copy_initiator dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .bytes_done(bytes_done), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_ready(cmd_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready)
`ifdef MEM_COPY_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic [1:0] t; logic [15:0] a; logic [7:0] d;} cmd_t;

  int checks = 0;
  int errors = 0;
  logic [7:0] mem [0:65535];
  logic [7:0] ref_mem [0:65535];
  cmd_t obs_q[$];
  int done_total = 0;
  int valid_total = 0;
  bit rand_mode = 0;
  int cmd_stall_cfg = 0;
  int rsp_delay_cfg = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory responder: drives cmd_ready/rsp_valid at negedge, books the handshakes the next posedge will see.
  task responder();
    int stall_left, rsp_left;
    bit rsp_pending, prev_stalled;
    logic [7:0] rsp_byte;
    cmd_t prev_cmd;
    stall_left = 0; rsp_left = 0; rsp_pending = 0; prev_stalled = 0; rsp_byte = '0; prev_cmd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cmd_ready = 0; rsp_valid = 0; rsp_pending = 0; prev_stalled = 0; stall_left = 0;
      end else begin
        if (prev_stalled)
          check_val("stall_hold", {cmd_valid, cmd_type, cmd_addr, cmd_data}, {1'b1, prev_cmd});
        check_val("valid_rdy_excl", cmd_valid & rsp_ready, 0);
        if (!cmd_valid) check_val("type_idle", cmd_type, 0);
        if (cmd_valid) begin
          if (stall_left > 0) begin cmd_ready = 0; stall_left--; end
          else cmd_ready = 1;
        end else begin
          cmd_ready  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
          stall_left = rand_mode ? int'($urandom_range(0, 3)) : cmd_stall_cfg;
        end
        if (rsp_pending) begin
          if (rsp_left > 0) begin rsp_valid = 0; rsp_left--; end
          else begin rsp_valid = 1; rsp_data = rsp_byte; end
        end else begin
          rsp_valid = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
          rsp_data  = 8'($urandom);
        end
        if (cmd_valid && cmd_ready) begin
          obs_q.push_back({cmd_type, cmd_addr, cmd_data});
          if (cmd_type == 2'd1) begin
            rsp_pending = 1;
            rsp_byte    = mem[cmd_addr];
            rsp_left    = rand_mode ? int'($urandom_range(0, 4)) : rsp_delay_cfg;
          end else if (cmd_type == 2'd2) begin
            mem[cmd_addr] = cmd_data;
          end
        end
        if (rsp_valid && rsp_ready) begin
          check_val("rsp_expected", rsp_pending, 1);
          rsp_pending = 0;
        end
        prev_stalled = cmd_valid && !cmd_ready;
        prev_cmd     = {cmd_type, cmd_addr, cmd_data};
        if (done) done_total++;
        if (cmd_valid) valid_total++;
      end
    end
  endtask

  // Reference: sequential forward byte copy, one READ then one WRITE per byte.
  task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input logic [16:0] n, input bit zero_wait);
    cmd_t exp_q[$];
    logic [15:0] ra, wa, sum;
    logic [7:0] b;
    int obs_base, done_base, valid_base, lat, limit, bad;
    ref_mem = mem;
    sum = '0;
    for (int i = 0; i < int'(n); i++) begin
      ra = s + 16'(i);
      wa = d + 16'(i);
      b  = ref_mem[ra];
      exp_q.push_back({2'd1, ra, 8'h00});
      exp_q.push_back({2'd2, wa, b});
      ref_mem[wa] = b;
      sum = sum + 16'(b);
    end
    obs_base = obs_q.size(); done_base = done_total; valid_base = valid_total;
    limit = 60 * int'(n) + 40;
    @(negedge clk);
    start = 1; src_addr = s; dst_addr = d; len = n;
    @(negedge clk);
    src_addr = 16'($urandom); dst_addr = 16'($urandom); len = 17'($urandom_range(0, 9));
    start = ($urandom_range(0, 3) == 0);
    check_val("busy_rise", busy, n != 0);
`ifdef MEM_COPY_CHECKSUM_EN
    check_val("csum_clear", checksum, 0);
`endif
    lat = 1;
    while (!done && lat < limit) begin
      @(negedge clk);
      lat++;
      start = !done && ($urandom_range(0, 3) == 0);
    end
    start = 0;
    if (!done) begin
      check_val("done_timeout", 0, 1);
      return;
    end
    if (zero_wait) check_val("latency", lat, 4 * int'(n) + 2);
    check_val("busy_fall", busy, 0);
    check_val("bytes_done", bytes_done, n);
`ifdef MEM_COPY_CHECKSUM_EN
    check_val("checksum", checksum, sum);
`endif
    @(negedge clk);
    check_val("done_single", done, 0);
    check_val("done_count", done_total - done_base, 1);
    check_val("bytes_done_hold", bytes_done, n);
`ifdef MEM_COPY_CHECKSUM_EN
    check_val("checksum_hold", checksum, sum);
`endif
    if (n == 0) check_val("no_cmd_valid", valid_total - valid_base, 0);
    check_val("cmd_count", obs_q.size() - obs_base, exp_q.size());
    for (int i = 0; i < exp_q.size() && obs_base + i < obs_q.size(); i++)
      check_val($sformatf("cmd%0d", i), obs_q[obs_base + i], exp_q[i]);
    bad = 0;
    for (int a = 0; a < 65536; a++) if (mem[a] !== ref_mem[a]) bad++;
    check_val("mem_image", bad, 0);
    $display("copy src=%h dst=%h len=%0d cycles=%0d cmds=%0d", s, d, n, lat, obs_q.size() - obs_base);
  endtask

  task automatic reset_mid_transfer();
    int base, wait_cyc;
    rand_mode = 0; cmd_stall_cfg = 0; rsp_delay_cfg = 40;
    base = obs_q.size();
    @(negedge clk);
    start = 1; src_addr = 16'h3000; dst_addr = 16'h4000; len = 17'd8;
    @(negedge clk);
    start = 0;
    wait_cyc = 0;
    while (!((obs_q.size() - base >= 3) && rsp_ready) && wait_cyc < 300) begin
      @(negedge clk);
      wait_cyc++;
    end
    check_val("rst_reached_rd_wait", (obs_q.size() - base >= 3) && rsp_ready, 1);
    check_val("rst_pre_busy", busy, 1);
    #2 rst = 1;
    #1;
    check_val("rst_async_cmd_valid", cmd_valid, 0);
    check_val("rst_async_rsp_ready", rsp_ready, 0);
    check_val("rst_async_busy", busy, 0);
    check_val("rst_async_bytes_done", bytes_done, 0);
    $display("reset asserted mid-transfer at t=%0t", $time);
    repeat (2) @(negedge clk);
    rst = 0;
    rsp_delay_cfg = 0;
    check_val("rst_bytes_done", bytes_done, 0);
  endtask

  initial begin
    logic [15:0] s, d;
    rst = 1; start = 0; src_addr = '0; dst_addr = '0; len = '0;
    cmd_ready = 0; rsp_valid = 0; rsp_data = '0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    fork
      responder();
    join_none
    repeat (3) @(negedge clk);
    check_val("reset_outputs", {busy, done, bytes_done, cmd_valid, cmd_type, cmd_addr, cmd_data, rsp_ready}, 0);
`ifdef MEM_COPY_CHECKSUM_EN
    check_val("reset_checksum", checksum, 0);
`endif
    rst = 0;

    mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22; mem[16'h0102] = 8'h33; mem[16'h0103] = 8'h44;
    run_copy(16'h0100, 16'h0200, 17'd4, 1);
    check_val("basic_dst", {mem[16'h0200], mem[16'h0201], mem[16'h0202], mem[16'h0203]}, 32'h11223344);

    run_copy(16'h1234, 16'h2345, 17'd0, 1);

    cmd_stall_cfg = 5; rsp_delay_cfg = 3;
    run_copy(16'h0500, 16'h0600, 17'd6, 0);
    cmd_stall_cfg = 0; rsp_delay_cfg = 0;

    run_copy(16'hFFFE, 16'h0010, 17'd4, 1);
    run_copy(16'h0700, 16'h0701, 17'd5, 1);
    run_copy(16'h0805, 16'h0803, 17'd6, 1);

    reset_mid_transfer();
    run_copy(16'h3000, 16'h4000, 17'd8, 1);

    rand_mode = 1;
    for (int k = 0; k < 10; k++) begin
      s = 16'($urandom);
      d = ($urandom_range(0, 1) == 1) ? s + 16'($urandom_range(0, 20)) - 16'd10 : 16'($urandom);
      run_copy(s, d, 17'($urandom_range(1, 16)), 0);
    end
    rand_mode = 0;

`ifdef MEM_COPY_CHECKSUM_EN
    mem[16'h0300] = 8'hFF; mem[16'h0301] = 8'hFF; mem[16'h0302] = 8'hFF; mem[16'h0303] = 8'h05;
    run_copy(16'h0300, 16'h0400, 17'd4, 1);
    check_val("checksum_spec", checksum, 16'h0302);
    mem[16'h0500] = 8'h01;
    run_copy(16'h0500, 16'h0900, 17'd1, 1);
    check_val("checksum_restart", checksum, 16'h0001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
